// File: rtl/tank_trouble_soc_keyevent_in.sv
// Fabric-to-CPU key event FIFO with an Avalon-MM slave for draining and a level IRQ
// for pending data or a dropped event.
module tank_trouble_soc_keyevent_in #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready
);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_MASK   = 2'd2,
        REG_FLUSH  = 2'd3
    } reg_addr_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       count;
    logic              overflow;
    logic [1:0]        mask;

    logic full;
    logic empty;
    logic rd_en;
    logic wr_en;
    logic push;
    logic pop;
    logic flush;
    logic ovf_set;
    logic ovf_clr;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

    assign rd_en   = chipselect && !read_n;
    assign wr_en   = chipselect && !write_n;
    assign push    = in_valid && in_ready;
    assign pop     = rd_en && (reg_addr_t'(address) == REG_DATA) && !empty;
    assign flush   = wr_en && (reg_addr_t'(address) == REG_FLUSH) && writedata[0];
    assign ovf_set = in_valid && !in_ready;
    assign ovf_clr = wr_en && (reg_addr_t'(address) == REG_STATUS) && writedata[8];

    // Only a few writedata bits are meaningful; the rest are deliberately ignored.
    logic unused_wdata;
    assign unused_wdata = ^{writedata[31:9], writedata[7:2]};

    // NOTE: the storage array has no reset; pointers and count define what is valid,
    // so clearing the entries would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail] <= in_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            mask     <= 2'b00;
        end else begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + AW'(1);
                if (pop)  head <= head + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end

            // A new overflow on the same edge as a clear must survive.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            if (wr_en && (reg_addr_t'(address) == REG_MASK)) begin
                mask <= writedata[1:0];
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        readdata = '0;
        case (reg_addr_t'(address))
            REG_DATA: begin
                if (!empty) readdata[DATA_W-1:0] = mem[head];
                readdata[31] = !empty;
            end
            REG_STATUS: begin
                readdata[AW:0] = count;
                readdata[8]    = overflow;
                readdata[9]    = full;
            end
            REG_MASK:  readdata[1:0] = mask;
            default:   readdata = '0;
        endcase
    end

    assign irq = (mask[0] && !empty) || (mask[1] && overflow);

endmodule

// File: tb/tb_tank_trouble_soc_keyevent_in.sv
// Randomised and directed bench for the key event FIFO, checked against a queue model.
module tb_tank_trouble_soc_keyevent_in;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    tank_trouble_soc_keyevent_in #(.DATA_W(8), .DEPTH(DEPTH), .AW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  q[$];
    logic        m_ovf;
    logic [1:0]  m_mask;
    logic [31:0] last_rd;
    logic        last_irq;
    logic        last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a)
            2'd0: if (q.size() > 0) r = {1'b1, 23'h0, q[0]};
            2'd1: r = q.size() | (m_ovf ? 32'h100 : 32'h0) | (q.size() == DEPTH ? 32'h200 : 32'h0);
            2'd2: r = {30'h0, m_mask};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic model_irq();
        return (m_mask[0] && q.size() > 0) || (m_mask[1] && m_ovf);
    endfunction

    // One bus/fabric cycle: drive away from the edge, compare, then advance the model.
    task automatic cycle(input logic [1:0] a, input logic cs, input logic rn, input logic wn,
                         input logic [31:0] wd, input logic v, input logic [7:0] d);
        logic was_full, do_push, do_pop, do_flush;
        @(negedge clk);
        address = a; chipselect = cs; read_n = rn; write_n = wn;
        writedata = wd; in_valid = v; in_data = d;
        #1;
        last_rd = readdata; last_irq = irq; last_ready = in_ready;
        check("readdata", readdata, model_read(a));
        check("in_ready", {31'h0, in_ready}, {31'h0, q.size() < DEPTH});
        check("irq", {31'h0, irq}, {31'h0, model_irq()});
        @(posedge clk);
        was_full = (q.size() == DEPTH);
        do_push  = v && !was_full;
        do_pop   = cs && !rn && a == 2'd0 && q.size() > 0;
        do_flush = cs && !wn && a == 2'd3 && wd[0];
        if (do_pop) void'(q.pop_front());
        if (do_flush) q.delete();
        else if (do_push) q.push_back(d);
        if (v && was_full) m_ovf = 1'b1;
        else if (cs && !wn && a == 2'd1 && wd[8]) m_ovf = 1'b0;
        if (cs && !wn && a == 2'd2) m_mask = wd[1:0];
    endtask

    task automatic push(input logic [7:0] d);
        cycle(2'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, d);
    endtask

    task automatic rd(input logic [1:0] a);
        cycle(a, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        cycle(a, 1'b1, 1'b1, 1'b0, wd, 1'b0, 8'h00);
    endtask

    task automatic idle();
        cycle(2'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic drain();
        while (q.size() > 0) rd(2'd0);
    endtask

    task automatic random_run(input int n);
        logic [1:0]  a;
        logic        cs, rn, wn, v;
        logic [31:0] wd;
        for (int i = 0; i < n; i++) begin
            a  = 2'($urandom_range(0, 3));
            cs = ($urandom_range(0, 1) == 1);
            rn = ($urandom_range(0, 2) == 0);
            wn = ($urandom_range(0, 3) != 0);
            wd = $urandom;
            if (a == 2'd3) wd[0] = ($urandom_range(0, 7) == 0);
            v  = ($urandom_range(0, 9) < 6);
            cycle(a, cs, rn, wn, wd, v, 8'($urandom));
        end
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        writedata = 32'h0; in_valid = 1'b0; in_data = 8'h00;
        q.delete(); m_ovf = 1'b0; m_mask = 2'b00;
        #1;
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Two codes in, read back in order, then empty.
        push(8'h1D); push(8'h23);
        rd(2'd1); check("status_two", last_rd, 32'h2);
        rd(2'd0); check("data_1d", last_rd, 32'h8000001D);
        rd(2'd0); check("data_23", last_rd, 32'h80000023);
        rd(2'd0); check("data_empty", last_rd, 32'h0);
        rd(2'd1); check("status_empty", last_rd, 32'h0);

        // Fill, hold 0x55, overflow, clear.
        for (int i = 0; i < DEPTH; i++) push(8'(i + 8'h40));
        cycle(2'd1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 8'h55);
        check("full_not_ready", {31'h0, last_ready}, 32'h0);
        check("status_full", last_rd, 32'h210);
        rd(2'd1); check("status_full_ovf", last_rd, 32'h310);
        wr(2'd1, 32'h100);
        rd(2'd1); check("status_ovf_clr", last_rd, 32'h210);

        // Full: simultaneous pop and in_valid -> pop only, then push accepted.
        cycle(2'd0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 8'hAA);
        check("full_pop_head", last_rd, 32'h80000040);
        cycle(2'd1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 8'hAA);
        check("count15_ready", {31'h0, last_ready}, 32'h1);
        check("count15_status", last_rd, 32'h10F);
        rd(2'd1); check("refull_status", last_rd, 32'h310);
        drain();
        wr(2'd1, 32'h100);

        // IRQ on data, then on overflow.
        wr(2'd2, 32'h1);
        idle(); check("irq_idle_low", {31'h0, last_irq}, 32'h0);
        push(8'h07); check("irq_push_edge", {31'h0, last_irq}, 32'h0);
        idle(); check("irq_data_high", {31'h0, last_irq}, 32'h1);
        rd(2'd0); check("irq_read_data", last_rd, 32'h80000007);
        idle(); check("irq_data_low", {31'h0, last_irq}, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) push(8'(i));
        wr(2'd2, 32'h2); drain();
        idle(); check("irq_ovf_high", {31'h0, last_irq}, 32'h1);
        wr(2'd1, 32'h100);
        idle(); check("irq_ovf_low", {31'h0, last_irq}, 32'h0);
        wr(2'd2, 32'h0);

        // Flush with concurrent push, then wrap the pointers.
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        rd(2'd1); check("status_five", last_rd, 32'h5);
        cycle(2'd3, 1'b1, 1'b1, 1'b0, 32'h1, 1'b1, 8'h99);
        rd(2'd1); check("flush_count", last_rd, 32'h0);
        rd(2'd0); check("flush_data", last_rd, 32'h0);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] c;
            c = 8'($urandom);
            push(c);
            rd(2'd0); check("wrap_data", last_rd, {1'b1, 23'h0, c});
        end

        random_run(3000);

        // Reset in the middle of traffic with 9 entries queued.
        wr(2'd3, 32'h1);
        for (int i = 0; i < 9; i++) push(8'(8'h60 + i));
        wr(2'd2, 32'h3);
        @(negedge clk);
        address = 2'd1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_count", readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        address = 2'd2;
        #1;
        check("rst_mask", readdata, 32'h0);
        q.delete(); m_ovf = 1'b0; m_mask = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        random_run(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
